md_result_pipe: RTL and testbench
=================================

Name: md_result_pipe

Overview:
- Parametrised, pipelined output stage of the multiply/divide unit; sits between the iterative MD core and writeback.
- Takes the raw 2*XLEN magnitude result (product, or quotient||remainder) with operand signs and op code.
- Applies two's-complement sign correction, high/low/word selection and RISC-V divide-by-zero/overflow results.
- valid/ready on both sides, tag passthrough, 2-cycle latency, full throughput.

Parameters:
XLEN, 64, datapath width (32 or 64); W-ops legal only when XLEN=64
TAG_W, 5, width of opaque tag carried alongside each result (rd index)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
valid_i  in  1  upstream result valid
ready_o  out  1  stage can accept
raw_i  in  2*XLEN  product magnitude, or {quotient, remainder} magnitudes
dividend_i  in  XLEN  original signed rs1 (special cases)
signs_i  in  2  [1]=rs1 negative, [0]=rs2 negative
md_op_i  in  4  [2]=div, [3]=word, [1:0]=sub-op
dz_i  in  1  divisor was zero
ovf_i  in  1  signed overflow (most-negative / -1)
tag_i  in  TAG_W  tag
valid_o  out  1  result valid
ready_i  in  1  downstream accepts
result_o  out  XLEN  final result
tag_o  out  TAG_W  tag of result_o

Behaviour:
- One clock, clk_i; reset asynchronous, active-low (rst_ni). Reset: valid_o=0, result_o=0, tag_o=0, all internal valids/data 0; ready_o=1 after reset.
- Transfer in on valid_i&ready_o; out on valid_o&ready_i. Latency: accepted cycle N -> valid_o high in cycle N+2 (if not stalled).
- S1 (capture register): latches raw_i, dividend_i, signs, op, dz, ovf, tag.
- S2 (output register): computes from S1 and registers result_o/tag_o.
- S1 advances when S2 is empty or draining; bubble-free: S1 and S2 both full with ready_i=1 moves one result per cycle.
- Multiply, md_op_i[2]=0:
  - P_s = product negated iff signs differ.
  - P_su = negated iff signs_i[1].
  - 00 MUL -> P_s[XLEN-1:0], or sext(P_s[31:0]) if word.
  - 01 MULH -> P_s[2XLEN-1:XLEN].
  - 10 MULHSU -> P_su high half.
  - 11 MULHU -> raw high half.
- Divide, md_op_i[2]=1: Q=raw high half, R=raw low half.
  - Signed Q negated iff signs differ; signed R negated iff signs_i[1].
  - 00 DIV, 01 DIVU, 10 REM, 11 REMU; word -> sext of low 32 bits.
- Special cases, divide only; dz_i has priority over ovf_i:
  - dz_i: quotient = all ones; remainder = dividend_i (sext low 32 if word).
  - ovf_i (signed ops only): quotient = dividend_i (sext if word); remainder = 0.
- Negation is modulo 2^(2*XLEN); negating zero gives zero.
- Stall: valid_o held, result_o/tag_o stable until ready_i.
- Reset mid-operation: all in-flight results discarded, none emitted.

Optional Feature:
- Macro MD_RESULT_PIPE_SKID_EN.
- Defined: adds a one-entry skid register at input. ready_o is a registered signal with no combinational path from ready_i. One extra accepted item is held in skid when stalled; throughput unchanged.
- Undefined: ready_o = ~s1_valid | (~s2_valid | ready_i), combinational from ready_i.
- Latency 2 in both builds when unstalled.

Decomposition:
- Shared package md_pkg:
  - Op-code localparams: MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU, MD_WORD_BIT, MD_DIV_BIT.
  - Typedef md_op_t (4 bits).
  - Struct md_req_t {raw, dividend, signs, op, dz, ovf, tag}.
- One natural sub-module: md_sign_fix, a combinational negate/select for one width, instantiated once for the 2*XLEN product and once per XLEN Q/R.

Test Plan:
1. XLEN=64, MULH, raw=128'h1 (1*1), signs=2'b10 -> result_o=64'hFFFF_FFFF_FFFF_FFFF, valid_o exactly 2 cycles after accept.
2. DIVW, raw={64'd3,64'd1}, signs=2'b10 -> result_o=64'hFFFF_FFFF_FFFF_FFFD. REMW, same inputs -> 64'hFFFF_FFFF_FFFF_FFFF.
3. DIV, dz_i=1, dividend_i=7 -> result_o=all ones. REM, same -> 7. DIV, ovf_i=1, dividend_i=64'h8000_0000_0000_0000 -> 64'h8000_0000_0000_0000. REM, same -> 0.
4. Back-to-back 8 ops with ready_i=1 -> 8 results on 8 consecutive cycles, tags in order. Then ready_i=0 for 5 cycles -> output stable, no loss, no duplication.
5. Assert rst_ni low with both stages full -> valid_o=0 immediately (async), no stale result after release.
6. With MD_RESULT_PIPE_SKID_EN: random ready_i toggling, 1000 ops vs reference model -> zero mismatches, and no combinational ready_i->ready_o path (lint/formal check).

Source files
------------

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - Op codes, op type and request record shared by the MD result pipe
package md_pkg;

  // Default configuration widths used by the md_req_t record layout
  localparam int MD_XLEN  = 64;
  localparam int MD_TAG_W = 5;

  typedef logic [3:0] md_op_t;

  // md_op[2] selects divide, md_op[3] selects the 32-bit word form
  localparam int MD_WORD_BIT = 3;
  localparam int MD_DIV_BIT  = 2;

  localparam md_op_t MD_MUL    = 4'b0000;
  localparam md_op_t MD_MULH   = 4'b0001;
  localparam md_op_t MD_MULHSU = 4'b0010;
  localparam md_op_t MD_MULHU  = 4'b0011;
  localparam md_op_t MD_DIV    = 4'b0100;
  localparam md_op_t MD_DIVU   = 4'b0101;
  localparam md_op_t MD_REM    = 4'b0110;
  localparam md_op_t MD_REMU   = 4'b0111;

  typedef struct packed {
    logic [2*MD_XLEN-1:0] raw;
    logic [MD_XLEN-1:0]   dividend;
    logic [1:0]           signs;
    md_op_t               op;
    logic                 dz;
    logic                 ovf;
    logic [MD_TAG_W-1:0]  tag;
  } md_req_t;

  // Divide sub-ops with an even code are the signed forms (DIV, REM)
  function automatic logic md_div_is_signed(input md_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - Conditional two's-complement negate of one magnitude
module md_sign_fix #(
  parameter int W = 64
) (
  input  logic [W-1:0] mag,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negation wraps modulo 2^W, so a zero magnitude stays zero
  always_comb begin
    res = mag;
    if (neg) begin
      res = ~mag + W'(1);
    end
  end

endmodule

// File: rtl/md_result_pipe.sv
// rtl/md_result_pipe.sv - Two-stage MD result pipe; MD_RESULT_PIPE_SKID_EN adds an input skid entry
module md_result_pipe
  import md_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2*XLEN-1:0] raw_i,
  input  logic [XLEN-1:0]   dividend_i,
  input  logic [1:0]        signs_i,
  input  logic [3:0]        md_op_i,
  input  logic              dz_i,
  input  logic              ovf_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [TAG_W-1:0]  tag_o
);

  // Same field order as md_req_t, sized by this instance's parameters
  typedef struct packed {
    logic [2*XLEN-1:0] raw;
    logic [XLEN-1:0]   dividend;
    logic [1:0]        signs;
    md_op_t            op;
    logic              dz;
    logic              ovf;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t in_req;
  req_t s1_req;
  req_t s1_next;
  logic s1_valid;
  logic s2_valid;
  logic s2_ready;
  logic s1_free;
  logic s1_load;

  assign in_req = '{raw: raw_i, dividend: dividend_i, signs: signs_i, op: md_op_t'(md_op_i),
                    dz: dz_i, ovf: ovf_i, tag: tag_i};

  assign s2_ready = ~s2_valid | ready_i;
  assign s1_free  = ~s1_valid | s2_ready;

`ifdef MD_RESULT_PIPE_SKID_EN
  logic skid_valid;
  req_t skid_req;

  // ready_o comes straight from a flop, so ready_i never reaches it combinationally
  assign ready_o = ~skid_valid;
  assign s1_load = s1_free & (skid_valid | valid_i);
  assign s1_next = skid_valid ? skid_req : in_req;

  // Park an accepted item here when S1 cannot take it; hand it to S1 first once it frees
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_valid <= 1'b0;
      skid_req   <= '0;
    end else if (skid_valid) begin
      if (s1_free) begin
        skid_valid <= 1'b0;
      end
    end else if (valid_i && !s1_free) begin
      skid_valid <= 1'b1;
      skid_req   <= in_req;
    end
  end
`else
  assign ready_o = s1_free;
  assign s1_load = valid_i & s1_free;
  assign s1_next = in_req;
`endif

  // S1 capture register: refills whenever its current content moves on or it is empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else if (s1_free) begin
      s1_valid <= s1_load;
      if (s1_load) begin
        s1_req <= s1_next;
      end
    end
  end

  logic            is_div;
  logic            is_word;
  logic [1:0]      sub_op;
  logic            sign_diff;
  logic            div_signed;
  logic            prod_neg;
  logic            quot_neg;
  logic            rem_neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] q_final;
  logic [XLEN-1:0] r_final;
  logic [XLEN-1:0] sel;
  logic [XLEN-1:0] result_d;

  assign is_div     = s1_req.op[MD_DIV_BIT];
  assign is_word    = s1_req.op[MD_WORD_BIT];
  assign sub_op     = s1_req.op[1:0];
  assign sign_diff  = s1_req.signs[1] ^ s1_req.signs[0];
  assign div_signed = md_div_is_signed(s1_req.op);
  assign quot_neg   = div_signed & sign_diff;
  assign rem_neg    = div_signed & s1_req.signs[1];

  // Product sign: both operands signed for MUL/MULH, only rs1 for MULHSU, none for MULHU
  always_comb begin
    prod_neg = 1'b0;
    case (sub_op)
      2'b00, 2'b01: prod_neg = sign_diff;
      2'b10:        prod_neg = s1_req.signs[1];
      default:      prod_neg = 1'b0;
    endcase
  end

  md_sign_fix #(.W(2*XLEN)) u_prod_fix (
    .mag (s1_req.raw),
    .neg (prod_neg),
    .res (prod)
  );

  md_sign_fix #(.W(XLEN)) u_quot_fix (
    .mag (s1_req.raw[2*XLEN-1:XLEN]),
    .neg (quot_neg),
    .res (quot)
  );

  md_sign_fix #(.W(XLEN)) u_rem_fix (
    .mag (s1_req.raw[XLEN-1:0]),
    .neg (rem_neg),
    .res (rem)
  );

  // Override divide results for zero divisor (wins) and signed overflow, then pick the half
  always_comb begin
    q_final = quot;
    r_final = rem;
    if (s1_req.dz) begin
      q_final = '1;
      r_final = s1_req.dividend;
    end else if (s1_req.ovf && div_signed) begin
      q_final = s1_req.dividend;
      r_final = '0;
    end
    if (is_div) begin
      sel = sub_op[1] ? r_final : q_final;
    end else if (sub_op == 2'b00) begin
      sel = prod[XLEN-1:0];
    end else begin
      sel = prod[2*XLEN-1:XLEN];
    end
    result_d = is_word ? XLEN'($signed(sel[31:0])) : sel;
  end

  // S2 output register: holds result and tag steady while the consumer stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      result_o <= '0;
      tag_o    <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result_o <= result_d;
        tag_o    <= s1_req.tag;
      end
    end
  end

  assign valid_o = s2_valid;

endmodule

// File: tb/tb_md_result_pipe.sv
// tb/tb_md_result_pipe.sv - Self-checking bench for md_result_pipe
module tb_md_result_pipe;
  import md_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_i, ready_o, valid_o, ready_i, dz_i, ovf_i;
  logic [2*XLEN-1:0] raw_i;
  logic [XLEN-1:0]   dividend_i, result_o;
  logic [1:0]        signs_i;
  logic [3:0]        md_op_i;
  logic [TAG_W-1:0]  tag_i, tag_o;

  always #5 clk = ~clk;

  md_result_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .raw_i(raw_i),
    .dividend_i(dividend_i), .signs_i(signs_i), .md_op_i(md_op_i), .dz_i(dz_i), .ovf_i(ovf_i),
    .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o)
  );

  typedef struct {
    logic [127:0] raw;
    logic [63:0]  dividend;
    logic [1:0]   signs;
    logic [3:0]   op;
    logic         dz;
    logic         ovf;
    logic [63:0]  exp;
  } vec_t;

  typedef struct {
    logic [63:0]      exp;
    logic [TAG_W-1:0] tag;
    bit               chk_lat;
    int               acc_cyc;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   out_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rec_out = 0;
  bit   rand_on = 0;
  logic [TAG_W-1:0] next_tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every output handshake pops the oldest expected entry
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_output: got tag %0d result %h, want no output", tag_o, result_o);
      end else begin
        e = sb.pop_front();
        check("result", result_o, e.exp);
        check("tag", 64'(tag_o), 64'(e.tag));
        if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
        if (rec_out) out_cyc.push_back(cyc);
      end
    end
  end

  function automatic vec_t mk(input logic [127:0] raw, input logic [63:0] dvd, input logic [1:0] s,
                              input logic [3:0] op, input logic dz, input logic ovf, input logic [63:0] exp);
    vec_t v;
    v.raw = raw; v.dividend = dvd; v.signs = s; v.op = op; v.dz = dz; v.ovf = ovf; v.exp = exp;
    return v;
  endfunction

  // Reference multiply: raw is the operand magnitude product, expectation is the true signed product
  function automatic vec_t mk_mul(input logic [1:0] sub, input bit word, input logic [63:0] a, input logic [63:0] b);
    vec_t v;
    bit sa, sbb, an, bn;
    logic [63:0] ma, mb;
    logic [127:0] pa, pb, full;
    if (word) begin
      sub = 2'b00;
      a = {{32{a[31]}}, a[31:0]};
      b = {{32{b[31]}}, b[31:0]};
    end
    sa  = (sub != 2'b11);
    sbb = (sub == 2'b00) || (sub == 2'b01);
    an  = sa && a[63];
    bn  = sbb && b[63];
    ma  = an ? -a : a;
    mb  = bn ? -b : b;
    v.raw = {64'd0, ma} * {64'd0, mb};
    v.signs = {a[63], b[63]};
    v.dividend = {$urandom(), $urandom()};
    v.op = {word, 1'b0, sub};
    v.dz = 1'b0;
    v.ovf = 1'b0;
    pa = sa ? {{64{a[63]}}, a} : {64'd0, a};
    pb = sbb ? {{64{b[63]}}, b} : {64'd0, b};
    full = pa * pb;
    if (word) v.exp = {{32{full[31]}}, full[31:0]};
    else if (sub == 2'b00) v.exp = full[63:0];
    else v.exp = full[127:64];
    return v;
  endfunction

  // Reference divide: RISC-V semantics computed directly from the signed operands
  function automatic vec_t mk_div(input logic [1:0] sub, input bit word, input logic [63:0] a, input logic [63:0] b);
    vec_t v;
    bit sgn, an, bn;
    logic [63:0] ma, mb, q, r, res;
    logic [31:0] a32, b32, ma32, mb32, q32, r32, res32;
    sgn = !sub[0];
    v.op = {word, 1'b1, sub};
    if (word) begin
      a32 = a[31:0];
      b32 = b[31:0];
      an = sgn && a32[31];
      bn = sgn && b32[31];
      ma32 = an ? -a32 : a32;
      mb32 = bn ? -b32 : b32;
      v.dz = (b32 == 32'd0);
      v.ovf = sgn && (a32 == 32'h8000_0000) && (b32 == 32'hffff_ffff);
      v.dividend = {32'($urandom()), a32};
      v.signs = {a32[31], b32[31]};
      if (v.dz) begin
        q32 = '1; r32 = a32; v.raw = {a, b};
      end else begin
        v.raw = {32'd0, ma32 / mb32, 32'd0, ma32 % mb32};
        if (v.ovf) begin q32 = a32; r32 = 32'd0; end
        else if (sgn) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
        else begin q32 = a32 / b32; r32 = a32 % b32; end
      end
      res32 = sub[1] ? r32 : q32;
      v.exp = {{32{res32[31]}}, res32};
    end else begin
      an = sgn && a[63];
      bn = sgn && b[63];
      ma = an ? -a : a;
      mb = bn ? -b : b;
      v.dz = (b == 64'd0);
      v.ovf = sgn && (a == 64'h8000_0000_0000_0000) && (b == '1);
      v.dividend = a;
      v.signs = {a[63], b[63]};
      if (v.dz) begin
        q = '1; r = a; v.raw = {b, a};
      end else begin
        v.raw = {ma / mb, ma % mb};
        if (v.ovf) begin q = a; r = 64'd0; end
        else if (sgn) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
        else begin q = a / b; r = a % b; end
      end
      res = sub[1] ? r : q;
      v.exp = res;
    end
    return v;
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [31:0] r;
    logic [63:0] v;
    r = $urandom();
    case ($urandom_range(0, 4))
      0: v = {$urandom(), $urandom()};
      1: v = 64'(r[3:0]);
      2: v = -64'(r[3:0]) - 64'd1;
      3: case (r[2:0])
           3'd0: v = 64'h8000_0000_0000_0000;
           3'd1: v = '1;
           3'd2: v = 64'd0;
           3'd3: v = 64'h7fff_ffff_ffff_ffff;
           3'd4: v = 64'd1;
           default: v = 64'hffff_ffff_8000_0000;
         endcase
      default: v = {{32{r[31]}}, r};
    endcase
    return v;
  endfunction

  function automatic vec_t rand_vec();
    logic [1:0] sub;
    bit word;
    logic [63:0] a, b;
    sub = 2'($urandom_range(0, 3));
    word = 1'($urandom_range(0, 1));
    a = rnd_op();
    b = rnd_op();
    if ($urandom_range(0, 7) == 0) begin
      a = word ? 64'hffff_ffff_8000_0000 : 64'h8000_0000_0000_0000;
      b = '1;
    end
    if ($urandom_range(0, 1) == 1) return mk_div(sub, word, a, b);
    return mk_mul(sub, word && (sub == 2'b00), a, b);
  endfunction

  // Present one item, wait (bounded) for acceptance, record its expectation
  task automatic send(input vec_t v, input bit chk);
    sb_t e;
    int n;
    raw_i = v.raw; dividend_i = v.dividend; signs_i = v.signs; md_op_i = v.op;
    dz_i = v.dz; ovf_i = v.ovf; tag_i = next_tag; valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got ready_o=0, want 1");
    end else begin
      e.exp = v.exp; e.tag = next_tag; e.chk_lat = chk; e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    next_tag++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held_res;
    logic [TAG_W-1:0] held_tag;
    valid_i = 0; ready_i = 1; raw_i = '0; dividend_i = '0; signs_i = '0;
    md_op_i = '0; dz_i = 0; ovf_i = 0; tag_i = '0;

    tbl.push_back(mk(128'h1, 64'd0, 2'b10, MD_MULH, 0, 0, 64'hffff_ffff_ffff_ffff));
    tbl.push_back(mk({64'd3, 64'd1}, 64'd0, 2'b10, MD_DIV | 4'b1000, 0, 0, 64'hffff_ffff_ffff_fffd));
    tbl.push_back(mk({64'd3, 64'd1}, 64'd0, 2'b10, MD_REM | 4'b1000, 0, 0, 64'hffff_ffff_ffff_ffff));
    tbl.push_back(mk(128'd0, 64'd7, 2'b00, MD_DIV, 1, 0, 64'hffff_ffff_ffff_ffff));
    tbl.push_back(mk(128'd0, 64'd7, 2'b00, MD_REM, 1, 0, 64'd7));
    tbl.push_back(mk({64'h8000_0000_0000_0000, 64'd0}, 64'h8000_0000_0000_0000, 2'b11, MD_DIV, 0, 1, 64'h8000_0000_0000_0000));
    tbl.push_back(mk({64'h8000_0000_0000_0000, 64'd0}, 64'h8000_0000_0000_0000, 2'b11, MD_REM, 0, 1, 64'd0));
    tbl.push_back(mk(128'd0, 64'h8000_0000_0000_0005, 2'b10, MD_DIVU, 1, 0, 64'hffff_ffff_ffff_ffff));
    tbl.push_back(mk(128'd0, 64'h8000_0000_0000_0005, 2'b10, MD_REMU, 1, 0, 64'h8000_0000_0000_0005));
    tbl.push_back(mk({64'd9, 64'd2}, 64'd0, 2'b11, MD_DIVU, 0, 1, 64'd9));
    tbl.push_back(mk(128'd2, 64'd0, 2'b01, MD_MUL, 0, 0, 64'hffff_ffff_ffff_fffe));
    tbl.push_back(mk(128'h0000_0001_0000_0003, 64'd0, 2'b01, MD_MUL | 4'b1000, 0, 0, 64'hffff_ffff_ffff_fffd));
    tbl.push_back(mk(128'd0, 64'd0, 2'b10, MD_MULH, 0, 0, 64'd0));
    tbl.push_back(mk({64'd5, 64'd0}, 64'd0, 2'b11, MD_MULHU, 0, 0, 64'd5));
    tbl.push_back(mk(128'h1, 64'd0, 2'b01, MD_MULHSU, 0, 0, 64'd0));
    tbl.push_back(mk({64'h8000_0000, 64'd0}, 64'd0, 2'b00, MD_DIVU | 4'b1000, 0, 0, 64'hffff_ffff_8000_0000));
    tbl.push_back(mk(128'd0, 64'h1234_5678_8000_0001, 2'b10, MD_REM | 4'b1000, 1, 0, 64'hffff_ffff_8000_0001));
    tbl.push_back(mk({64'h8000_0000, 64'd0}, 64'h0000_0000_8000_0000, 2'b11, MD_DIV | 4'b1000, 0, 1, 64'hffff_ffff_8000_0000));
    tbl.push_back(mk(128'd0, 64'h8000_0000_0000_0000, 2'b11, MD_DIV, 1, 1, 64'hffff_ffff_ffff_ffff));
    tbl.push_back(mk(128'd0, 64'h8000_0000_0000_0000, 2'b11, MD_REM, 1, 1, 64'h8000_0000_0000_0000));
    for (int i = 0; i < 16; i++) tbl.push_back(rand_vec());

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_result_o", result_o, 64'd0);
    check("rst_tag_o", 64'(tag_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready_o", 64'(ready_o), 64'd1);

    // Directed and reference vectors, back to back, latency checked
    for (int i = 0; i < tbl.size(); i++) send(tbl[i], 1'b1);
    drain();

    // Eight back-to-back ops must emerge on consecutive cycles
    rec_out = 1;
    out_cyc.delete();
    for (int i = 0; i < 8; i++) send(rand_vec(), 1'b1);
    drain();
    rec_out = 0;
    check("burst_count", 64'(out_cyc.size()), 64'd8);
    for (int i = 1; i < out_cyc.size(); i++) check("burst_gap", 64'(out_cyc[i] - out_cyc[i-1]), 64'd1);

    // Output stall: result and tag held for five cycles, then drained without loss
    ready_i = 0;
    send(rand_vec(), 1'b0);
    send(rand_vec(), 1'b0);
    @(negedge clk);
    held_res = result_o;
    held_tag = tag_o;
    check("stall_valid", 64'(valid_o), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid_hold", 64'(valid_o), 64'd1);
      check("stall_result_hold", result_o, held_res);
      check("stall_tag_hold", 64'(tag_o), 64'(held_tag));
    end
    @(posedge clk);
    #1;
    ready_i = 1;
    drain();

    // Asynchronous reset with both stages full discards everything
    ready_i = 0;
    send(rand_vec(), 1'b0);
    send(rand_vec(), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(valid_o), 64'd0);
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    ready_i = 1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_idle", 64'(valid_o), 64'd0);
    end
    @(posedge clk);
    #1;

    // Random backpressure against the reference model
    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          ready_i = ($urandom_range(0, 2) != 0);
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_vec(), 1'b0);
    end
    rand_on = 0;
    @(posedge clk);
    #2;
    ready_i = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
